// File: rtl/csr_bank.sv
// csr_bank: bank of RISC-V style CSRs with a software access port and per-CSR hardware write ports.
// csr_op uses the funct3 encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 = no access.
module csr_bank #(
   parameter int NumCsr = 4,
   parameter int CsrWidth = 5,
   parameter logic [11:0] BaseAddr = 12'h300,
   parameter logic [NumCsr-1:0][CsrWidth-1:0] ResetVal = '0,
   parameter logic [NumCsr-1:0] RoMask = '0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             csr_enable,
   input  logic [11:0]                      csr_addr,
   input  logic [4:0]                       rs1_zimm,
   input  logic [31:0]                      rs1_data,
   input  logic [2:0]                       csr_op,
   input  logic [NumCsr-1:0][CsrWidth-1:0]  ext_data,
   input  logic [NumCsr-1:0]                ext_write_enable,
   output logic [31:0]                      out,
   output logic                             match,
   output logic                             illegal,
   output logic [NumCsr-1:0][CsrWidth-1:0]  csr_q,
   output logic [NumCsr-1:0]                changed
);
   localparam int IdxW = NumCsr > 1 ? $clog2(NumCsr) : 1;
   logic [11:0] off;
   logic [IdxW-1:0] idx;
   logic [CsrWidth-1:0] old, src, wdata;
   logic sw_we;
   logic [NumCsr-1:0][CsrWidth-1:0] nxt;
   assign off = csr_addr - BaseAddr;
   assign match = (csr_addr >= BaseAddr) && (off < 12'(NumCsr));
   assign idx = off[IdxW-1:0];
   assign old = match ? csr_q[idx] : '0;
   assign out = 32'(old);
   assign src = csr_op[2] ? CsrWidth'(rs1_zimm) : rs1_data[CsrWidth-1:0];
   assign wdata = csr_op[1:0] == 2'b01 ? src : csr_op[1:0] == 2'b10 ? (old | src) : (old & ~src);
   // set/clear with x0 or a zero immediate is a pure read
   assign sw_we = csr_enable & match & (csr_op[1:0] != 2'b00) & ~(csr_op[1] & (rs1_zimm == 5'd0));
   assign illegal = sw_we & RoMask[idx];
   always_comb begin
      nxt = csr_q;
      for (int i = 0; i < NumCsr; i++)
         nxt[i] = ext_write_enable[i] ? ext_data[i] :
                  (sw_we && !RoMask[i] && idx == IdxW'(i)) ? wdata : csr_q[i];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csr_q <= ResetVal;
         changed <= '0;
      end else begin
         for (int i = 0; i < NumCsr; i++) changed[i] <= nxt[i] != csr_q[i];
         csr_q <= nxt;
      end
   end
endmodule

// File: tb/tb_csr_bank.sv
// tb_csr_bank: directed stimulus pushes expectations into a scoreboard; a negedge monitor pops and compares.
module tb_csr_bank;
   localparam logic [2:0] NOP = 3'b000, RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101, RSI = 3'b110;
   localparam int K_OUT = 0, K_MATCH = 1, K_ILL = 2, K_Q = 3, K_CHG = 4;
   logic clk = 0, reset = 0, csr_enable = 0;
   logic [11:0] csr_addr = 12'h300;
   logic [4:0] rs1_zimm = 0;
   logic [31:0] rs1_data = 0;
   logic [2:0] csr_op = NOP;
   logic [3:0][4:0] ext_data = '0;
   logic [3:0] ext_write_enable = '0;
   logic [31:0] out;
   logic match, illegal;
   logic [3:0][4:0] csr_q;
   logic [3:0] changed;
   int tests = 0, fails = 0;
   bit done = 0;
   typedef struct {int k; int i; logic [31:0] e; string n;} exp_t;
   exp_t sb[$];

   csr_bank #(.NumCsr(4), .CsrWidth(5), .BaseAddr(12'h300), .ResetVal('0), .RoMask(4'b1000)) dut (
      .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr), .rs1_zimm(rs1_zimm),
      .rs1_data(rs1_data), .csr_op(csr_op), .ext_data(ext_data), .ext_write_enable(ext_write_enable),
      .out(out), .match(match), .illegal(illegal), .csr_q(csr_q), .changed(changed));

   always #5 clk = ~clk;

   function automatic logic [31:0] act(int k, int i);
      case (k)
         K_OUT:   return out;
         K_MATCH: return 32'(match);
         K_ILL:   return 32'(illegal);
         K_Q:     return 32'(csr_q[i]);
         default: return 32'(changed);
      endcase
   endfunction

   initial begin
      exp_t r;
      logic [31:0] a;
      while (!done) begin
         @(negedge clk);
         while (sb.size() > 0) begin
            r = sb.pop_front();
            a = act(r.k, r.i);
            tests++;
            if (a !== r.e) begin
               fails++;
               $display("FAIL %s: got %0h expected %0h at %0t", r.n, a, r.e, $time);
            end
         end
      end
   end

   task automatic ex(int k, int i, logic [31:0] e, string n);
      exp_t r;
      r.k = k; r.i = i; r.e = e; r.n = n;
      sb.push_back(r);
   endtask

   task automatic acc(logic en, logic [11:0] a, logic [2:0] op, logic [4:0] z, logic [31:0] d);
      @(posedge clk);
      #1;
      csr_enable = en; csr_addr = a; csr_op = op; rs1_zimm = z; rs1_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      acc(0, 12'h300, NOP, 0, 0);
      for (int i = 0; i < 4; i++) ex(K_Q, i, 0, "reset_q");
      ex(K_CHG, 0, 0, "reset_changed");
      ex(K_MATCH, 0, 1, "reset_match");
      @(negedge clk); #1 reset = 1;
      acc(1, 12'h300, RW, 5'd1, 32'b1011);
      ex(K_OUT, 0, 0, "rw_prewrite_out"); ex(K_MATCH, 0, 1, "rw_match"); ex(K_ILL, 0, 0, "rw_illegal");
      acc(0, 12'h300, NOP, 0, 0);
      ex(K_OUT, 0, 5'b01011, "rw_out"); ex(K_CHG, 0, 4'b0001, "rw_changed");
      acc(1, 12'h300, RS, 5'd1, 32'b1100);
      ex(K_CHG, 0, 0, "changed_one_cycle"); ex(K_OUT, 0, 5'b01011, "rs_prewrite");
      acc(1, 12'h300, RC, 5'd1, 32'b1100);
      ex(K_OUT, 0, 5'b01111, "rs_result"); ex(K_CHG, 0, 4'b0001, "rs_changed");
      acc(1, 12'h300, RSI, 5'd0, 32'h1f);
      ex(K_OUT, 0, 5'b00011, "rc_result");
      acc(1, 12'h300, RS, 5'd0, 32'b10000);
      ex(K_CHG, 0, 0, "rsi_zero_nochange");
      acc(1, 12'h300, NOP, 5'd3, 32'h1f);
      ex(K_OUT, 0, 5'b00011, "rs_x0_nowrite");
      acc(1, 12'h301, RW, 5'd1, 32'hffff_ffff);
      ex(K_OUT, 0, 0, "rw1_prewrite"); ex(K_Q, 0, 5'b00011, "invalid_op_nowrite");
      acc(0, 12'h304, NOP, 0, 0);
      ex(K_MATCH, 0, 0, "miss_match"); ex(K_OUT, 0, 0, "miss_out");
      ex(K_Q, 1, 5'b11111, "rw_trunc_q1"); ex(K_CHG, 0, 4'b0010, "q1_changed");
      acc(1, 12'h2ff, RW, 5'd1, 32'h1);
      ex(K_MATCH, 0, 0, "below_base_match");
      acc(1, 12'h303, RWI, 5'd5, 0);
      ex(K_ILL, 0, 1, "ro_illegal"); ex(K_CHG, 0, 0, "below_base_nowrite");
      acc(0, 12'h303, NOP, 0, 0);
      ex(K_Q, 3, 0, "ro_unchanged"); ex(K_ILL, 0, 0, "illegal_clear"); ex(K_CHG, 0, 0, "ro_no_pulse");
      ext_write_enable = 4'b1000; ext_data[3] = 5'b10101;
      acc(0, 12'h303, NOP, 0, 0);
      ext_write_enable = '0;
      ex(K_Q, 3, 5'b10101, "ext_ro_write"); ex(K_CHG, 0, 4'b1000, "ext_changed");
      acc(1, 12'h302, RW, 5'd1, 32'b00001);
      ext_write_enable = 4'b0101; ext_data[2] = 5'b11000; ext_data[0] = 5'b00111;
      ex(K_ILL, 0, 0, "collide_illegal");
      acc(1, 12'h302, RW, 5'd1, 32'b11000);
      ext_write_enable = '0;
      ex(K_Q, 2, 5'b11000, "ext_wins"); ex(K_Q, 0, 5'b00111, "ext_parallel");
      ex(K_CHG, 0, 4'b0101, "collide_changed");
      acc(0, 12'h300, NOP, 0, 0);
      ex(K_CHG, 0, 0, "equal_write_no_pulse");
      acc(1, 12'h300, RW, 5'd1, 32'b10101);
      ex(K_OUT, 0, 5'b00111, "pre_reset_out");
      @(negedge clk); #1 reset = 0;
      acc(0, 12'h300, NOP, 0, 0);
      ex(K_Q, 0, 0, "reset_discard_q"); ex(K_Q, 2, 0, "reset_q2"); ex(K_CHG, 0, 0, "reset_discard_chg");
      @(negedge clk); #1 reset = 1;
      acc(1, 12'h301, RWI, 5'd9, 0);
      ex(K_CHG, 0, 0, "post_reset_chg");
      acc(0, 12'h301, NOP, 0, 0);
      ex(K_OUT, 0, 5'd9, "post_reset_write");
      repeat (2) @(posedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      done = 1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 SHALL have parameter NumCsr, default 4, number of CSRs in the bank (1..32).
REQ-002 SHALL have parameter CsrWidth, default 5, implemented bits per CSR (1..32).
REQ-003 SHALL have parameter BaseAddr, default 12'h300; CSR i resides at BaseAddr+i.
REQ-004 SHALL have parameter ResetVal, default all zero, NumCsr x CsrWidth packed reset values.
REQ-005 SHALL have parameter RoMask, default 0, NumCsr bits; bit i set = CSR i read-only to software.
REQ-006 SHALL have port clk  in  1  system clock, rising edge active.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port csr_enable  in  1  CSR instruction valid this cycle.
REQ-009 SHALL have port csr_addr  in  CsrAddrT (12)  CSR address.
REQ-010 SHALL have port rs1_zimm  in  r (5)  rs1 index / zero-extended immediate.
REQ-011 SHALL have port rs1_data  in  word (32)  rs1 register value.
REQ-012 SHALL have port csr_op  in  csr_op_t  CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI; any other value = no CSR access.
REQ-013 SHALL have port ext_data  in  NumCsr x CsrWidth  hardware write data per CSR.
REQ-014 SHALL have port ext_write_enable  in  NumCsr  hardware write strobe per CSR.
REQ-015 SHALL have port out  out  word (32)  read data to rd.
REQ-016 SHALL have port match  out  1  csr_addr hits the bank.
REQ-017 SHALL have port illegal  out  1  software write attempt to read-only CSR.
REQ-018 SHALL have port csr_q  out  NumCsr x CsrWidth  live CSR contents.
REQ-019 SHALL have port changed  out  NumCsr  registered one-cycle pulse, CSR i value changed.

Function
REQ-020 match SHALL be combinational: 1 iff BaseAddr <= csr_addr < BaseAddr+NumCsr; idx = csr_addr-BaseAddr.
REQ-021 out SHALL be combinational: zero-extended pre-write value of CSR idx when match, else 0 (csr_enable ignored for read).
REQ-022 Source operand SHALL be rs1_data[CsrWidth-1:0] for CSRRW/RS/RC; for immediate ops, 5-bit rs1_zimm zero-extended/truncated to CsrWidth.
REQ-023 New value SHALL be: RW/RWI = src; RS/RSI = old | src; RC/RCI = old & ~src.
REQ-024 sw_we SHALL be csr_enable & match & valid op & ~(op in {RS,RC,RSI,RCI} & rs1_zimm==0); RW/RWI always write.
REQ-025 Write SHALL take effect on the rising edge following the access cycle; csr_q/out show new value next cycle.
REQ-026 When sw_we targets CSR i with RoMask[i]=1, CSR SHALL remain unchanged and illegal SHALL be 1 combinationally that cycle; otherwise illegal = 0.
REQ-027 ext_write_enable[i] SHALL load ext_data[i] into CSR i at the rising edge, regardless of RoMask.
REQ-028 Simultaneous ext and software write to same CSR SHALL resolve in favour of ext_data; software write discarded silently (illegal unaffected).
REQ-029 Ext writes to different CSRs and a software write to a third SHALL all commit in the same cycle.
REQ-030 changed[i] SHALL be 1 for exactly the cycle after an edge where CSR i's stored value differed before and after; writing an equal value SHALL NOT pulse.

Reset
REQ-031 While reset=0, CSR i SHALL asynchronously equal ResetVal[i] and changed SHALL be 0; out/match/illegal follow combinational rules.
REQ-032 Reset asserted mid-access SHALL discard the pending write; first edge after release SHALL perform normal writes.

Verification (NumCsr=4, CsrWidth=5, BaseAddr=0x300, RoMask=4'b1000)
REQ-033 Reset; CSRRW addr 0x300, x1=0b1011 -> out=0 that cycle, next cycle out=0b01011, changed[0] one-cycle pulse.
REQ-034 CSRRS 0b1100 -> 0b01111; CSRRC 0b1100 -> 0b00011; CSRRSI rs1_zimm=0 -> no write, changed[0]=0.
REQ-035 CSRRW x1=32'hffff_ffff at 0x301 -> csr_q[1]=5'b11111; csr_addr=0x304 -> match=0, out=0 within 1 ns.
REQ-036 CSRRWI 5 at 0x303 (read-only) -> illegal=1, csr_q[3] unchanged; ext_write_enable[3] with 0b10101 -> csr_q[3]=0b10101.
REQ-037 Same-cycle CSRRW 0b00001 and ext write 0b11000 to 0x302 -> csr_q[2]=0b11000.
REQ-038 Assert reset between access cycle and edge -> CSR stays ResetVal, no changed pulse.
